// File: rtl/icache_pkg.sv
// Shared constants, state encodings and helpers for the instruction cache.
// Optional hit/miss statistics are enabled with the ICACHE_STATS_EN macro.
package icache_pkg;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Default number of index bits (2^8 single-word lines).
    localparam int unsigned ICACHE_INDEX_BITS = 8;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_MISS = 1'b1
    } icache_state_e;

    // Memory controller only ever sees word-aligned fetch addresses.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read by index, synchronous write; valid bits cleared by reset.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic [31:0]         data_mem[LINES];

    // Set the valid bit of the line being filled.
    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[wr_index] = HIGH;
        end
    end

    // Valid bits are the only array state that needs a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data payload; meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: serves hits in one cycle, fetches misses
// through the memory controller handshake, and aborts on jump_flag.
// Define ICACHE_STATS_EN to build the hit/miss counters.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic        mc_valid,
    output logic [31:0] mc_addr,
    input  logic        mc_enable,
    input  logic [31:0] mc_inst,
    input  logic        jump_flag,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

    icache_state_e state_q, state_d;
    logic [29:0]   req_addr_q, req_addr_d;  // word address of the outstanding request
    logic          inst_valid_q, inst_valid_d;
    logic [31:0]   inst_q, inst_d;
    logic          mc_valid_q, mc_valid_d;
    logic [31:0]   mc_addr_q, mc_addr_d;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  we;
    logic                  hit;
    logic                  hit_inc;
    logic                  miss_inc;
    logic [1:0]            unused_byte_offset;

    assign unused_byte_offset = if_addr[1:0];

    icache_data_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_data_array (
        .clk     (clk),
        .rst     (rst),
        .rd_index(if_addr[INDEX_BITS+1:2]),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we      (we),
        .wr_index(req_addr_q[INDEX_BITS-1:0]),
        .wr_tag  (req_addr_q[29:INDEX_BITS]),
        .wr_data (mc_inst)
    );

    assign hit = rd_valid && (rd_tag == if_addr[31:INDEX_BITS+2]);

    // Next-state: jump flushes first, rdy low freezes, otherwise IDLE/MISS flow.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        inst_valid_d = LOW;
        inst_d       = inst_q;
        mc_valid_d   = mc_valid_q;
        mc_addr_d    = mc_addr_q;
        we           = LOW;
        hit_inc      = LOW;
        miss_inc     = LOW;
        if (jump_flag) begin
            state_d    = ICACHE_IDLE;
            mc_valid_d = LOW;
            // A response landing with the flush is still correct data for req_addr.
            we = (state_q == ICACHE_MISS) && mc_enable && rdy;
        end else if (rdy) begin
            case (state_q)
                ICACHE_IDLE: begin
                    if (if_valid) begin
                        req_addr_d = if_addr[31:2];
                        if (hit) begin
                            inst_valid_d = HIGH;
                            inst_d       = rd_data;
                            hit_inc      = HIGH;
                        end else begin
                            mc_valid_d = HIGH;
                            mc_addr_d  = word_align(if_addr);
                            state_d    = ICACHE_MISS;
                            miss_inc   = HIGH;
                        end
                    end
                end
                ICACHE_MISS: begin
                    if (mc_enable) begin
                        we           = HIGH;
                        mc_valid_d   = LOW;
                        inst_valid_d = HIGH;
                        inst_d       = mc_inst;
                        state_d      = ICACHE_IDLE;
                    end
                end
                default: state_d = ICACHE_IDLE;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ICACHE_IDLE;
            req_addr_q   <= '0;
            inst_valid_q <= LOW;
            inst_q       <= '0;
            mc_valid_q   <= LOW;
            mc_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            mc_valid_q   <= mc_valid_d;
            mc_addr_q    <= mc_addr_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    // Dropping valid while not ready makes the controller abandon the fetch;
    // the held request re-issues once rdy returns.
    assign mc_valid   = mc_valid_q & rdy;
    assign mc_addr    = mc_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Free-running wrap-around statistics counters.
    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, hit_inc};
        miss_count_d = miss_count_q + {31'd0, miss_inc};
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    logic unused_stats;
    assign unused_stats = hit_inc ^ miss_inc;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache with a scoreboard of expected
// instructions; each inst_valid pulse pops and compares one entry.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic        mc_valid;
    logic [31:0] mc_addr;
    logic        mc_enable;
    logic [31:0] mc_inst;
    logic        jump_flag;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;
    logic [31:0] sb[$];

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .if_valid  (if_valid),
        .if_addr   (if_addr),
        .inst_valid(inst_valid),
        .inst      (inst),
        .mc_valid  (mc_valid),
        .mc_addr   (mc_addr),
        .mc_enable (mc_enable),
        .mc_inst   (mc_inst),
        .jump_flag (jump_flag),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge, and scoreboard any response.
    task automatic tick();
        logic [31:0] exp;
        @(posedge clk);
        #1;
        if (inst_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_inst_valid", 32'(inst_valid), 32'd0);
            end else begin
                exp = sb.pop_front();
                chk("inst_data", inst, exp);
            end
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef ICACHE_STATS_EN
        chk({tag, "_hit_count"}, hit_count, exp_hits);
        chk({tag, "_miss_count"}, miss_count, exp_misses);
`else
        chk({tag, "_hit_count"}, hit_count, 32'd0);
        chk({tag, "_miss_count"}, miss_count, 32'd0);
`endif
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] data);
        sb.push_back(data);
        if_valid = 1'b1;
        if_addr  = addr;
        tick();
        if_valid = 1'b0;
        exp_hits++;
        chk("hit_inst_valid", 32'(inst_valid), 32'd1);
        chk("hit_no_mc_valid", 32'(mc_valid), 32'd0);
        tick();
        chk("hit_pulse_end", 32'(inst_valid), 32'd0);
    endtask

    task automatic fetch_miss(input logic [31:0] addr);
        if_valid = 1'b1;
        if_addr  = addr;
        tick();
        if_valid = 1'b0;
        exp_misses++;
        chk("miss_mc_valid", 32'(mc_valid), 32'd1);
        chk("miss_mc_addr", mc_addr, {addr[31:2], 2'b00});
        chk("miss_no_inst_valid", 32'(inst_valid), 32'd0);
    endtask

    // Controller completes after wait_cycles more cycles of held request.
    task automatic respond(input logic [31:0] data, input int wait_cycles);
        logic [31:0] held_addr;
        held_addr = mc_addr;
        for (int i = 0; i < wait_cycles; i++) begin
            tick();
            chk("hold_mc_valid", 32'(mc_valid), 32'd1);
            chk("hold_mc_addr", mc_addr, held_addr);
        end
        mc_enable = 1'b1;
        mc_inst   = data;
        sb.push_back(data);
        tick();
        mc_enable = 1'b0;
        chk("fill_inst_valid", 32'(inst_valid), 32'd1);
        chk("fill_mc_valid_drop", 32'(mc_valid), 32'd0);
        tick();
        chk("fill_pulse_end", 32'(inst_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        rdy       = 1'b1;
        if_valid  = 1'b0;
        if_addr   = '0;
        mc_enable = 1'b0;
        mc_inst   = '0;
        jump_flag = 1'b0;
        #12;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_mc_valid", 32'(mc_valid), 32'd0);
        chk("rst_mc_addr", mc_addr, 32'd0);
        chk_stats("rst");
        @(negedge clk);
        rst = 1'b0;

        // Cold fetch, answer after 5 cycles of mc_valid.
        fetch_miss(32'h0000_0004);
        respond(32'h0010_0093, 4);
        // Refetch hits; byte offset bits are ignored.
        fetch_hit(32'h0000_0004, 32'h0010_0093);
        chk_stats("refetch");
        fetch_hit(32'h0000_0006, 32'h0010_0093);

        // Conflict on index 1 replaces the line.
        fetch_miss(32'h0000_0404);
        respond(32'hAAAA_0001, 2);
        fetch_hit(32'h0000_0404, 32'hAAAA_0001);
        fetch_miss(32'h0000_0004);
        respond(32'h0010_0093, 1);

        // Jump in the second cycle of a miss; a late response is ignored.
        fetch_miss(32'h0000_0010);
        tick();
        jump_flag = 1'b1;
        tick();
        jump_flag = 1'b0;
        chk("jump_mc_valid", 32'(mc_valid), 32'd0);
        chk("jump_inst_valid", 32'(inst_valid), 32'd0);
        mc_enable = 1'b1;
        mc_inst   = 32'h1234_5678;
        tick();
        mc_enable = 1'b0;
        chk("late_enable_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("late_enable_quiet", 32'(inst_valid), 32'd0);
        fetch_miss(32'h0000_0010);
        respond(32'h0000_0013, 0);

        // Jump coincident with mc_enable still fills the line.
        fetch_miss(32'h0000_0008);
        tick();
        jump_flag = 1'b1;
        mc_enable = 1'b1;
        mc_inst   = 32'hDEAD_BEEF;
        tick();
        jump_flag = 1'b0;
        mc_enable = 1'b0;
        chk("jump_fill_inst_valid", 32'(inst_valid), 32'd0);
        chk("jump_fill_mc_valid", 32'(mc_valid), 32'd0);
        tick();
        chk("jump_fill_quiet", 32'(inst_valid), 32'd0);
        fetch_hit(32'h0000_0008, 32'hDEAD_BEEF);

        // rdy low masks mc_valid; request re-issues unchanged.
        fetch_miss(32'h0000_000E);
        rdy = 1'b0;
        tick();
        chk("rdy_low_mc_valid", 32'(mc_valid), 32'd0);
        tick();
        chk("rdy_low_hold_addr", mc_addr, 32'h0000_000C);
        rdy = 1'b1;
        tick();
        chk("rdy_back_mc_valid", 32'(mc_valid), 32'd1);
        chk("rdy_back_mc_addr", mc_addr, 32'h0000_000C);
        respond(32'h0000_0EEE, 1);
        chk_stats("pre_reset");

        // Reset in the middle of a miss.
        fetch_miss(32'h0000_0020);
        tick();
        rst = 1'b1;
        #1;
        exp_hits   = 0;
        exp_misses = 0;
        chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_inst", inst, 32'd0);
        chk("midrst_mc_valid", 32'(mc_valid), 32'd0);
        chk("midrst_mc_addr", mc_addr, 32'd0);
        chk_stats("midrst");
        rst = 1'b0;
        fetch_miss(32'h0000_0004);
        respond(32'h0010_0093, 2);
        chk_stats("final");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
